// File: rtl/decode_queue.sv
// RV32I decode queue: instructions are decoded on entry and buffered in a small
// FIFO so issue sees a ready-made operand/immediate record at the head.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic             out_alt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_use_rd,
    output logic             out_use_rs1,
    output logic             out_use_rs2,
    output logic [31:0]      out_imm,
    output logic             out_is_imm,
    output logic             out_is_pc,
    output logic             out_illegal,
    output logic [31:0]      out_pc,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rd;
        logic        use_rs1;
        logic        use_rs2;
        logic [31:0] imm;
        logic        is_imm;
        logic        is_pc;
        logic        illegal;
        logic [31:0] pc;
    } entry_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           dec;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;
    logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Register fields are passed through raw; only flags and imm depend on the class.
    always_comb begin
        dec         = '0;
        dec.opcode  = in_inst[6:0];
        dec.funct3  = in_inst[14:12];
        dec.rd      = in_inst[11:7];
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.pc      = in_pc;
        case (in_inst[6:0])
            7'b0110011: begin
                dec.use_rd = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
                dec.alt    = in_inst[30];
            end
            7'b0010011: begin
                dec.use_rd = 1'b1; dec.use_rs1 = 1'b1; dec.is_imm = 1'b1;
                dec.imm    = imm_i;
                dec.alt    = (in_inst[14:12] == 3'b101) ? in_inst[30] : 1'b0;
            end
            7'b0000011: begin
                dec.use_rd = 1'b1; dec.use_rs1 = 1'b1; dec.is_imm = 1'b1;
                dec.imm    = imm_i;
            end
            7'b0100011: begin
                dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1; dec.is_imm = 1'b1;
                dec.imm     = imm_s;
            end
            7'b1100011: begin
                dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
                dec.imm     = imm_b;
            end
            7'b0110111: begin
                dec.use_rd = 1'b1; dec.is_imm = 1'b1;
                dec.imm    = imm_u;
            end
            7'b0010111: begin
                dec.use_rd = 1'b1; dec.is_imm = 1'b1; dec.is_pc = 1'b1;
                dec.imm    = imm_u;
            end
            7'b1101111: begin
                dec.use_rd = 1'b1; dec.is_imm = 1'b1; dec.is_pc = 1'b1;
                dec.imm    = imm_j;
            end
            7'b1100111: begin
                if (in_inst[14:12] == 3'b000) begin
                    dec.use_rd = 1'b1; dec.use_rs1 = 1'b1; dec.is_imm = 1'b1;
                    dec.imm    = imm_i;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
        if (in_inst[11:7] == 5'd0) dec.use_rd = 1'b0;
    end

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = rdy_in && in_valid && in_ready && !flush_in;
    assign pop       = rdy_in && out_valid && out_ready && !flush_in;

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + (PTR_W+1)'(1);
        if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
    end

    // Flush only takes effect while enabled; reset wins over everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_d;
                tail_q  <= tail_d;
                count_q <= count_d;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push && !rst_in) mem_q[tail_q] <= dec;
    end

    assign out_opcode  = mem_q[head_q].opcode;
    assign out_funct3  = mem_q[head_q].funct3;
    assign out_alt     = mem_q[head_q].alt;
    assign out_rd      = mem_q[head_q].rd;
    assign out_rs1     = mem_q[head_q].rs1;
    assign out_rs2     = mem_q[head_q].rs2;
    assign out_use_rd  = mem_q[head_q].use_rd;
    assign out_use_rs1 = mem_q[head_q].use_rs1;
    assign out_use_rs2 = mem_q[head_q].use_rs2;
    assign out_imm     = mem_q[head_q].imm;
    assign out_is_imm  = mem_q[head_q].is_imm;
    assign out_is_pc   = mem_q[head_q].is_pc;
    assign out_illegal = mem_q[head_q].illegal;
    assign out_pc      = mem_q[head_q].pc;
    assign count       = count_q;

endmodule
